user_io_freq_meter: RTL and testbench

Input-side counterpart to the free-running LED/user_io divider: measures an external toggling signal instead of generating one. The block synchronizes a single user_io input into the clk_60mhz domain and detects rising edges. It counts those edges over a fixed gate window and presents each window's count through a valid/ack handshake. It sits next to the board LED logic and self-checks divider outputs looped back through a user_io pin.

---
 rtl/user_io_freq_meter.sv | 118 +++++++++++
 tb/tb_user_io_freq_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_io_freq_meter.sv
// Edge-counting frequency meter for a looped-back user_io pin: synchronizes sig_in,
// counts rising edges over a fixed gate window and hands each count out via valid/ack.
module user_io_freq_meter #(
  parameter int GATE_CYCLES = 6000000,
  parameter int COUNT_WIDTH = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_60mhz,
  input  logic                   rst,
  input  logic                   sig_in,
  output logic                   edge_pulse,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   count_valid,
  input  logic                   count_ack,
  output logic                   overflow,
  output logic                   overrun
);

  localparam int GATE_WIDTH = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [GATE_WIDTH-1:0]  gate_count;
  logic [COUNT_WIDTH-1:0] edge_count;
  logic                   sat;

  logic                   rise;
  logic                   close;
  logic                   ack_take;
  logic                   final_sat;
  logic [COUNT_WIDTH-1:0] edge_next;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rise      = 1'b0;
    close     = 1'b0;
    ack_take  = 1'b0;
    final_sat = 1'b0;
    edge_next = edge_count;

    rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    close    = (gate_count == GATE_LAST);
    ack_take = count_ack & count_valid;

    // Saturating increment; a rise that would wrap is flagged instead of counted.
    if (rise) begin
      if (edge_count == COUNT_MAX) begin
        final_sat = 1'b1;
      end else begin
        edge_next = edge_count + COUNT_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_pulse <= rise;
    end
  end

  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      gate_count <= '0;
    end else if (close) begin
      gate_count <= '0;
    end else begin
      gate_count <= gate_count + GATE_WIDTH'(1);
    end
  end

  // A rise in the close cycle is folded into the closing window via edge_next.
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      edge_count <= '0;
      sat        <= 1'b0;
    end else if (close) begin
      edge_count <= '0;
      sat        <= 1'b0;
    end else begin
      edge_count <= edge_next;
      if (final_sat) begin
        sat <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      overrun     <= 1'b0;
    end else if (close) begin
      count_out   <= edge_next;
      overflow    <= sat | final_sat;
      count_valid <= 1'b1;
      // An ack landing with the close consumes the old result, so nothing is lost.
      if (ack_take) begin
        overrun <= 1'b0;
      end else if (count_valid) begin
        overrun <= 1'b1;
      end
    end else if (ack_take) begin
      count_valid <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_user_io_freq_meter.sv
// Directed bench for user_io_freq_meter: 100-cycle gate, 4-bit counter, 2-stage sync.
module tb_user_io_freq_meter;

  localparam int GATE = 100;
  localparam int CW   = 4;

  logic          clk_60mhz;
  logic          rst;
  logic          sig_in;
  logic          edge_pulse;
  logic [CW-1:0] count_out;
  logic          count_valid;
  logic          count_ack;
  logic          overflow;
  logic          overrun;

  int tests = 0;
  int fails = 0;
  int wave_half = 0;
  int wave_cnt  = 0;

  user_io_freq_meter #(
    .GATE_CYCLES(GATE),
    .COUNT_WIDTH(CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk_60mhz  (clk_60mhz),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_pulse (edge_pulse),
    .count_out  (count_out),
    .count_valid(count_valid),
    .count_ack  (count_ack),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  initial clk_60mhz = 1'b0;
  always #5 clk_60mhz = ~clk_60mhz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the optional square wave toggles here.
  task automatic step();
    @(negedge clk_60mhz);
    if (wave_half > 0) begin
      wave_cnt++;
      if (wave_cnt == wave_half) begin
        wave_cnt = 0;
        sig_in   = ~sig_in;
      end
    end
  endtask

  task automatic set_wave(input int half);
    wave_half = half;
    wave_cnt  = 0;
    if (half == 0) sig_in = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!count_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  // Ack one cycle after count_valid was seen.
  task automatic consume();
    step();
    count_ack = 1'b1;
    step();
    count_ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".edge_pulse"},  32'(edge_pulse),  32'd0);
    check({tag, ".count_out"},   32'(count_out),   32'd0);
    check({tag, ".count_valid"}, 32'(count_valid), 32'd0);
    check({tag, ".overflow"},    32'(overflow),    32'd0);
    check({tag, ".overrun"},     32'(overrun),     32'd0);
  endtask

  initial begin
    int n;
    int m;
    rst       = 1'b1;
    sig_in    = 1'b0;
    count_ack = 1'b0;

    // 1: reset holds outputs low even with sig_in toggling; first close 100 cycles later.
    for (int i = 0; i < 4; i++) begin
      step();
      sig_in = ~sig_in;
    end
    step();
    check_zero("t1_reset");
    sig_in = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    wait_valid(200, n);
    check("t1_first_close_cycles", 32'(n), 32'd100);
    check("t1_count_out", 32'(count_out), 32'd0);
    check("t1_overflow",  32'(overflow),  32'd0);
    check("t1_overrun",   32'(overrun),   32'd0);

    // 2: a 3-cycle high on sig_in gives exactly one pulse, visible after edge k+2.
    count_ack = 1'b1;
    sig_in    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      count_ack = 1'b0;
      check($sformatf("t2_edge_pulse_c%0d", i), 32'(edge_pulse), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) sig_in = 1'b0;
    end
    check("t2_valid_acked", 32'(count_valid), 32'd0);
    wait_valid(200, n);
    check("t2_close_cycles", 32'(n), 32'd92);
    check("t2_count_out", 32'(count_out), 32'd1);

    // 3: period-10 square wave, each result acked one cycle after valid.
    set_wave(5);
    consume();
    for (int w = 0; w < 4; w++) begin
      wait_valid(200, n);
      check($sformatf("t3_w%0d_valid", w), 32'(count_valid), 32'd1);
      if (w > 0) begin
        check($sformatf("t3_w%0d_count_out", w), 32'(count_out), 32'd10);
        check($sformatf("t3_w%0d_overflow", w),  32'(overflow),  32'd0);
      end
      check($sformatf("t3_w%0d_overrun", w), 32'(overrun), 32'd0);
      consume();
    end

    // 4: period-4 wave gives 25 edges, saturating the 4-bit counter; then a quiet window.
    set_wave(2);
    wait_valid(200, n);
    consume();
    wait_valid(200, n);
    check("t4_sat_valid",     32'(count_valid), 32'd1);
    check("t4_sat_count_out", 32'(count_out),   32'd15);
    check("t4_sat_overflow",  32'(overflow),    32'd1);
    set_wave(0);
    consume();
    wait_valid(200, n);
    consume();
    wait_valid(200, n);
    check("t4_quiet_count_out", 32'(count_out), 32'd0);
    check("t4_quiet_overflow",  32'(overflow),  32'd0);
    consume();

    // 5: period-10 wave, results left unacked, then an ack and an ack landing on the close.
    set_wave(5);
    wait_valid(200, n);
    consume();
    wait_valid(200, n);
    check("t5_b_valid", 32'(count_valid), 32'd1);
    for (int i = 0; i < 99; i++) step();
    check("t5_pre_close_overrun", 32'(overrun), 32'd0);
    step();
    check("t5_ovr_valid",     32'(count_valid), 32'd1);
    check("t5_ovr_overrun",   32'(overrun),     32'd1);
    check("t5_ovr_count_out", 32'(count_out),   32'd10);
    count_ack = 1'b1;
    step();
    count_ack = 1'b0;
    check("t5_ack_valid",     32'(count_valid), 32'd0);
    check("t5_ack_overrun",   32'(overrun),     32'd0);
    check("t5_ack_count_out", 32'(count_out),   32'd10);
    wait_valid(200, n);
    check("t5_d_close_cycles", 32'(n), 32'd99);
    for (int i = 0; i < 99; i++) step();
    count_ack = 1'b1;
    step();
    count_ack = 1'b0;
    check("t5_same_valid",     32'(count_valid), 32'd1);
    check("t5_same_overrun",   32'(overrun),     32'd0);
    check("t5_same_count_out", 32'(count_out),   32'd10);
    check("t5_same_overflow",  32'(overflow),    32'd0);

    // 6: mid-window reset clears outputs at once; only post-reset edges are counted.
    for (int i = 0; i < 50; i++) step();
    #1;
    rst = 1'b1;
    set_wave(0);
    #1;
    check_zero("t6_async_reset");
    step();
    step();
    rst = 1'b0;
    n = 0;
    for (int p = 0; p < 3; p++) begin
      sig_in = 1'b1;
      step();
      step();
      sig_in = 1'b0;
      step();
      step();
      step();
      n += 5;
    end
    wait_valid(200, m);
    check("t6_close_cycles", 32'(n + m), 32'd100);
    check("t6_count_out",    32'(count_out), 32'd3);
    check("t6_overflow",     32'(overflow),  32'd0);
    check("t6_overrun",      32'(overrun),   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
